register_file: RTL and testbench

- MIPS-style 32 x 32-bit register file for the single-cycle CPU.
- Sits directly downstream of the 5-bit destination-register mux (RegDst: rt vs rd). That mux output drives write_reg here.
- Two combinational read ports feed the ALU operand path. One synchronous write port is committed on the rising clock edge.
- Register 0 is hardwired to zero.

---
 rtl/register_file.sv | 47 ++++
 tb/tb_register_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked write port.
// Register 0 reads as zero; register 29 ($sp) resets to SP_INIT.
module register_file #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_03FC,
    parameter int                BYPASS  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int SP_REG = 29;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;
    logic              byp1;
    logic              byp2;

    // An X on reg_write makes the if-condition false in simulation, so it never writes.
    assign wr_en = reg_write && (write_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_REG) ? SP_INIT : '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Write-through forwarding, suppressed while reset holds the array.
    assign byp1 = (BYPASS != 0) && !rst && wr_en && (read_reg1 == write_reg);
    assign byp2 = (BYPASS != 0) && !rst && wr_en && (read_reg2 == write_reg);

    assign read_data1 = (read_reg1 == '0) ? '0 : (byp1 ? write_data : regs[read_reg1]);
    assign read_data2 = (read_reg2 == '0) ? '0 : (byp2 ? write_data : regs[read_reg2]);

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one write-back and one write-through instance share stimulus,
// both checked against an array-based model of the architectural register state.
module tb_register_file;
    localparam logic [31:0] SP_INIT = 32'h0000_03FC;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    register_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(SP_INIT), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_nb), .read_data2(rd2_nb));

    register_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(SP_INIT), .BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_bp), .read_data2(rd2_bp));

    task automatic reset_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = SP_INIT;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit bypass);
        if (addr == 5'd0) return 32'h0;
        if (bypass && !rst && reg_write && write_reg != 5'd0 && addr == write_reg)
            return write_data;
        return model[addr];
    endfunction

    function automatic logic [4:0] regdst_mux(input bit op, input logic [4:0] rt, input logic [4:0] rd);
        return op ? rd : rt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, " nb.rd1"}, rd1_nb, exp_read(read_reg1, 1'b0));
        check({tag, " nb.rd2"}, rd2_nb, exp_read(read_reg2, 1'b0));
        check({tag, " bp.rd1"}, rd1_bp, exp_read(read_reg1, 1'b1));
        check({tag, " bp.rd2"}, rd2_bp, exp_read(read_reg2, 1'b1));
    endtask

    // Inputs change 1 time unit after a rising edge; the model commits at the edge.
    task automatic tick();
        bit          do_wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        do_wr = !rst && reg_write && (write_reg != 5'd0);
        wa = write_reg;
        wd = write_data;
        @(posedge clk);
        if (do_wr) model[wa] = wd;
        #1;
    endtask

    task automatic drive_write(input logic [4:0] wa, input logic [31:0] wd, input logic we);
        write_reg = wa;
        write_data = wd;
        reg_write = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        drive_write(5'd0, 32'h0, 1'b0);
        reset_model();
        #1;
        read_reg1 = 5'd29; read_reg2 = 5'd5;
        #1;
        check("reset sp during rst", rd1_nb, SP_INIT);
        check("reset r5 during rst", rd2_nb, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            read_reg1 = a[4:0];
            read_reg2 = 5'(31 - a);
            #1;
            check("reset sweep", rd1_nb, (a == 29) ? SP_INIT : 32'h0);
            check("reset sweep bp", rd2_bp, (a == 2) ? SP_INIT : 32'h0);
        end

        drive_write(5'd13, 32'hDEAD_BEEF, 1'b1);
        tick();
        reg_write = 1'b0;
        read_reg1 = 5'd13; read_reg2 = 5'd8;
        #1;
        check("basic r13", rd1_nb, 32'hDEAD_BEEF);
        check("basic r8", rd2_nb, 32'h0);
        check_reads("basic");

        drive_write(5'd0, 32'h1234_5678, 1'b1);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        tick();
        check("r0 write dropped nb", rd1_nb, 32'h0);
        check("r0 write dropped bp", rd2_bp, 32'h0);
        drive_write(5'd8, 32'd7, 1'b0);
        read_reg1 = 5'd8;
        tick();
        check("disabled write r8", rd1_nb, 32'h0);
        check("disabled write r8 bp", rd1_bp, 32'h0);

        drive_write(regdst_mux(1'b1, 5'd8, 5'd13), 32'h11, 1'b1);
        tick();
        drive_write(regdst_mux(1'b0, 5'd8, 5'd13), 32'h22, 1'b1);
        tick();
        reg_write = 1'b0;
        read_reg1 = 5'd13; read_reg2 = 5'd13;
        #1;
        check("regdst r13 p1", rd1_nb, 32'h11);
        check("regdst r13 p2", rd2_nb, 32'h11);
        read_reg1 = 5'd8; read_reg2 = 5'd8;
        #1;
        check("regdst r8 p1", rd1_bp, 32'h22);
        check("regdst r8 p2", rd2_bp, 32'h22);

        drive_write(5'd5, 32'hAAAA, 1'b1);
        tick();
        drive_write(5'd5, 32'hBBBB, 1'b1);
        read_reg1 = 5'd5; read_reg2 = 5'd8;
        #1;
        check("same-cycle nb before", rd1_nb, 32'hAAAA);
        check("same-cycle bp before", rd1_bp, 32'hBBBB);
        check("same-cycle other port", rd2_bp, 32'h22);
        tick();
        reg_write = 1'b0;
        #1;
        check("same-cycle nb after", rd1_nb, 32'hBBBB);
        check("same-cycle bp after", rd1_bp, 32'hBBBB);

        drive_write(5'd7, 32'hFFFF_0000, 1'b1);
        tick();
        reg_write = 1'b0;
        read_reg1 = 5'd7; read_reg2 = 5'd29;
        #1;
        check("r7 loaded", rd1_nb, 32'hFFFF_0000);
        #1;
        rst = 1'b1;
        reset_model();
        #1;
        check("async rst r7 nb", rd1_nb, 32'h0);
        check("async rst r7 bp", rd1_bp, 32'h0);
        check("async rst sp", rd2_nb, SP_INIT);
        drive_write(5'd7, 32'h1234_ABCD, 1'b1);
        #1;
        check("rst blocks bypass", rd1_bp, 32'h0);
        tick();
        check_reads("write under rst");
        reg_write = 1'b0;
        rst = 1'b0;
        #1;
        check("r7 after release", rd1_nb, 32'h0);
        drive_write(5'd7, 32'h0000_5A5A, 1'b1);
        tick();
        reg_write = 1'b0;
        #1;
        check("first write after release", rd1_nb, 32'h0000_5A5A);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                reset_model();
            end else begin
                rst = 1'b0;
            end
            read_reg1 = 5'($urandom_range(0, 31));
            read_reg2 = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            drive_write(($urandom_range(0, 2) == 0) ? read_reg1 : 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                        ($urandom_range(0, 3) != 0));
            #1;
            check_reads("random");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
